// File: rtl/lsu_mem_port_if.sv
// Request/response and memory-port bundle for lsu_mem_port.
// master = execute stage plus memory; slave = the load/store unit.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_rw;
  logic [31:0] mem_ain;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  mem_rw, mem_ain, mem_din,
    output mem_dout
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output mem_rw, mem_ain, mem_din,
    input  mem_dout
  );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32 load/store unit over a word-only memory port; sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned half/word accesses instead of masking the address.

// One byte lane of the store merge: keep the old memory byte or take the new one.
module lsu_byte_lane (
  input  logic       sel,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module lsu_mem_port #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_BITS  = $clog2(MEM_WORDS)
) (
  input logic          clock,
  input logic          reset,
  lsu_mem_port_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic                we;
    logic                uns;
    size_t               size;
    logic [IDX_BITS+1:0] addr;
    logic [31:0]         wdata;
  } req_t;

  state_t state;
  req_t   rq;
  req_t   nreq;
  logic   accept;

  // Bits above the word index alias onto the same memory word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:IDX_BITS+2];

  always_comb begin
    nreq       = '0;
    nreq.we    = bus.req_we;
    nreq.uns   = bus.req_funct3[2];
    nreq.addr  = bus.req_addr[IDX_BITS+1:0];
    nreq.wdata = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00:   nreq.size = SZ_B;
      2'b01:   nreq.size = SZ_H;
      default: nreq.size = SZ_W;
    endcase
`ifndef LSU_MISALIGN_TRAP_EN
    // Without the trap, force natural alignment so the access proceeds on the containing lane.
    if (nreq.size == SZ_H) nreq.addr[0]   = 1'b0;
    if (nreq.size == SZ_W) nreq.addr[1:0] = 2'b00;
`endif
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic mis_pend;
  assign misaligned = ((nreq.size == SZ_H) &&  nreq.addr[0]) ||
                      ((nreq.size == SZ_W) && (nreq.addr[1:0] != 2'b00));
`else
  assign bus.resp_misaligned = 1'b0;
`endif

  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // Store lane enables and the store data replicated across every lane it may land in.
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wrep;
  logic [NUM_LANES-1:0][7:0] merged;

  always_comb begin
    case (rq.size)
      SZ_B: begin
        be   = 4'b0001 << rq.addr[1:0];
        wrep = {4{rq.wdata[7:0]}};
      end
      SZ_H: begin
        be   = rq.addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{rq.wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = rq.wdata;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_byte_lane u_lane (
      .sel   (be[i]),
      .old_b (bus.mem_dout[8*i +: 8]),
      .new_b (wrep[i]),
      .out_b (merged[i])
    );
  end

  // Load lane extraction and extension.
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  always_comb begin
    ld_b = bus.mem_dout[{rq.addr[1:0], 3'b000} +: 8];
    ld_h = rq.addr[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
    case (rq.size)
      SZ_B:    ld_ext = {{24{!rq.uns && ld_b[7]}}, ld_b};
      SZ_H:    ld_ext = {{16{!rq.uns && ld_h[15]}}, ld_h};
      default: ld_ext = bus.mem_dout;
    endcase
  end

  // Write enable is gated by reset so an aborted merge never commits.
  assign bus.mem_rw  = !reset && ((state == WRITE) || ((state == MERGE) && rq.we));
  assign bus.mem_ain = {{(32-IDX_BITS){1'b0}}, rq.addr[IDX_BITS+1:2]};
  assign bus.mem_din = (state == MERGE) ? merged : rq.wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      rq             <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      bus.resp_misaligned <= 1'b0;
      mis_pend            <= 1'b0;
`endif
    end else begin
      bus.resp_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      bus.resp_misaligned <= 1'b0;
      // A rejected request answers one edge after accept while the FSM stays in IDLE.
      if (mis_pend) begin
        bus.resp_valid      <= 1'b1;
        bus.resp_misaligned <= 1'b1;
        bus.resp_rdata      <= '0;
        mis_pend            <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            rq <= nreq;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned) mis_pend <= 1'b1;
            else
`endif
            state <= (nreq.we && (nreq.size == SZ_W)) ? WRITE : READ;
          end
        end
        READ: state <= MERGE;
        MERGE: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= rq.we ? 32'd0 : ld_ext;
          state          <= IDLE;
        end
        WRITE: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
